// File: rtl/piso_serializer_if.sv
// ============================================================================
// Module      : piso_serializer_if
// Description : Word handshake, bit strobe and serial output bundle for the
//               parallel-in serial-out serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface piso_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic             shift_en;
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             serial_out;
    logic             bit_valid;
    logic             done;
    logic             busy;

    modport master (
        output shift_en, data_in, data_valid,
        input  data_ready, serial_out, bit_valid, done, busy
    );

    modport slave (
        input  shift_en, data_in, data_valid,
        output data_ready, serial_out, bit_valid, done, busy
    );
endinterface

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// Module      : piso_serializer
// Description : Accepts a WIDTH-bit word on a valid/ready handshake and emits
//               it one bit per shift_en strobe with bit_valid/done qualifiers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    piso_serializer_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_serial;
    logic             w_serial_nxt;
    logic             r_bit_valid;
    logic             w_bit_valid_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_out_bit;

    // Bit order is fixed at elaboration; both paths zero-fill the vacated end.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit = r_shift[WIDTH-1];
            assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit = r_shift[0];
            assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_serial    <= 1'b0;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_serial    <= w_serial_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_serial_nxt    = r_serial;
        w_bit_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.data_valid) begin
                    w_shift_nxt = bus.data_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.shift_en) begin
                    w_serial_nxt    = w_out_bit;
                    w_shift_nxt     = w_shifted;
                    w_bit_valid_nxt = 1'b1;
                    // Counter parks at zero on the last bit so it never exceeds WIDTH-1.
                    if (r_cnt == C_LAST) begin
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.data_ready = (r_state == ST_IDLE);
    assign bus.busy       = (r_state == ST_SHIFT);
    assign bus.serial_out = r_serial;
    assign bus.bit_valid  = r_bit_valid;
    assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// Module      : tb_piso_serializer
// Description : Directed self-checking bench for piso_serializer (MSB and LSB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic exp_sout;

    piso_serializer_if #(.WIDTH(8)) if_m ();
    piso_serializer_if #(.WIDTH(8)) if_l ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (if_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_m.data_valid = 1'b1; if_m.data_in = 8'hFF; if_m.shift_en = 1'b1;
        if_l.data_valid = 1'b1; if_l.data_in = 8'hFF; if_l.shift_en = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if ({if_m.data_ready, if_m.serial_out, if_m.bit_valid, if_m.done, if_m.busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_msb: got {rdy,sout,bv,done,busy}=%b want 10000",
                     {if_m.data_ready, if_m.serial_out, if_m.bit_valid, if_m.done, if_m.busy});
        end
        n_tests++;
        if ({if_l.data_ready, if_l.serial_out, if_l.bit_valid, if_l.done, if_l.busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_lsb: got {rdy,sout,bv,done,busy}=%b want 10000",
                     {if_l.data_ready, if_l.serial_out, if_l.bit_valid, if_l.done, if_l.busy});
        end
        if_m.data_valid = 1'b0; if_m.shift_en = 1'b0;
        if_l.data_valid = 1'b0; if_l.shift_en = 1'b0;
        rst = 1'b0;
        tick();
        n_tests++;
        if (if_m.busy !== 1'b0 || if_m.data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_nocapture: got busy=%b rdy=%b want busy=0 rdy=1", if_m.busy, if_m.data_ready);
        end
        exp_sout = 1'b0;
    endtask

    // Drives one word into the MSB-first unit and checks every bit edge.
    task automatic send_word_msb(input logic [7:0] word, input string name);
        if_m.data_in = word; if_m.data_valid = 1'b1; if_m.shift_en = 1'b1;
        tick();
        if_m.data_valid = 1'b0;
        n_tests++;
        if ({if_m.busy, if_m.data_ready, if_m.bit_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s_accept: got {busy,rdy,bv}=%b want 100", name,
                     {if_m.busy, if_m.data_ready, if_m.bit_valid});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_sout = word[7-i];
            n_tests++;
            if ({if_m.bit_valid, if_m.done, if_m.serial_out, if_m.data_ready} !==
                {1'b1, (i == 7), exp_sout, (i == 7)}) begin
                n_fail++;
                $display("FAIL %s_bit%0d: got {bv,done,sout,rdy}=%b want %b", name, i,
                         {if_m.bit_valid, if_m.done, if_m.serial_out, if_m.data_ready},
                         {1'b1, (i == 7), exp_sout, (i == 7)});
            end
        end
    endtask

    task automatic test_msb_basic();
        send_word_msb(8'hA5, "a5");
        tick();
        n_tests++;
        if ({if_m.bit_valid, if_m.done, if_m.serial_out, if_m.data_ready} !== {3'b001, 1'b1}) begin
            n_fail++;
            $display("FAIL a5_after: got {bv,done,sout,rdy}=%b want 0011",
                     {if_m.bit_valid, if_m.done, if_m.serial_out, if_m.data_ready});
        end
        if_m.shift_en = 1'b0;
    endtask

    task automatic test_sparse_strobe();
        logic [7:0] word;
        int         k;
        word = 8'h3C;
        k = 0;
        if_m.data_in = word; if_m.data_valid = 1'b1; if_m.shift_en = 1'b0;
        tick();
        if_m.data_valid = 1'b0;
        for (int c = 0; c < 27; c++) begin
            if_m.shift_en = ((c % 3) == 2);
            tick();
            if ((c % 3) == 2 && k < 8) begin
                exp_sout = word[7-k];
                n_tests++;
                if ({if_m.bit_valid, if_m.done, if_m.serial_out} !== {1'b1, (k == 7), exp_sout}) begin
                    n_fail++;
                    $display("FAIL sparse_bit%0d: got {bv,done,sout}=%b want %b", k,
                             {if_m.bit_valid, if_m.done, if_m.serial_out}, {1'b1, (k == 7), exp_sout});
                end
                k++;
            end else begin
                n_tests++;
                if ({if_m.bit_valid, if_m.done, if_m.serial_out} !== {2'b00, exp_sout}) begin
                    n_fail++;
                    $display("FAIL sparse_hold_c%0d: got {bv,done,sout}=%b want %b", c,
                             {if_m.bit_valid, if_m.done, if_m.serial_out}, {2'b00, exp_sout});
                end
            end
        end
        if_m.shift_en = 1'b0;
        n_tests++;
        if (if_m.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sparse_end_busy: got %b want 0", if_m.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2];
        words[0] = 8'h11;
        words[1] = 8'h22;
        if_m.data_in = words[0]; if_m.data_valid = 1'b1; if_m.shift_en = 1'b1;
        tick();
        if_m.data_in = words[1];
        for (int w = 0; w < 2; w++) begin
            if (w == 1) begin
                if_m.data_valid = 1'b0;
            end
            n_tests++;
            if ({if_m.busy, if_m.bit_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_accept%0d: got {busy,bv}=%b want 10", w, {if_m.busy, if_m.bit_valid});
            end
            for (int i = 0; i < 8; i++) begin
                tick();
                exp_sout = words[w][7-i];
                n_tests++;
                if ({if_m.bit_valid, if_m.done, if_m.serial_out} !== {1'b1, (i == 7), exp_sout}) begin
                    n_fail++;
                    $display("FAIL b2b_w%0d_bit%0d: got {bv,done,sout}=%b want %b", w, i,
                             {if_m.bit_valid, if_m.done, if_m.serial_out}, {1'b1, (i == 7), exp_sout});
                end
            end
            tick();
        end
        n_tests++;
        if ({if_m.busy, if_m.bit_valid, if_m.serial_out} !== {2'b00, exp_sout}) begin
            n_fail++;
            $display("FAIL b2b_end: got {busy,bv,sout}=%b want %b",
                     {if_m.busy, if_m.bit_valid, if_m.serial_out}, {2'b00, exp_sout});
        end
        if_m.shift_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        if_m.data_in = 8'hFF; if_m.data_valid = 1'b1; if_m.shift_en = 1'b1;
        tick();
        if_m.data_valid = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if ({if_m.bit_valid, if_m.serial_out, if_m.busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL midrst_pre: got {bv,sout,busy}=%b want 111",
                     {if_m.bit_valid, if_m.serial_out, if_m.busy});
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({if_m.data_ready, if_m.serial_out, if_m.bit_valid, if_m.done, if_m.busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL midrst_async: got {rdy,sout,bv,done,busy}=%b want 10000",
                     {if_m.data_ready, if_m.serial_out, if_m.bit_valid, if_m.done, if_m.busy});
        end
        tick();
        rst = 1'b0;
        exp_sout = 1'b0;
        send_word_msb(8'h81, "r81");
        tick();
        if_m.shift_en = 1'b0;
    endtask

    task automatic test_lsb_first();
        logic [7:0] word;
        word = 8'h01;
        if_l.data_in = word; if_l.data_valid = 1'b1; if_l.shift_en = 1'b1;
        tick();
        if_l.data_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if ({if_l.bit_valid, if_l.done, if_l.serial_out} !== {1'b1, (i == 7), word[i]}) begin
                n_fail++;
                $display("FAIL lsb_bit%0d: got {bv,done,sout}=%b want %b", i,
                         {if_l.bit_valid, if_l.done, if_l.serial_out}, {1'b1, (i == 7), word[i]});
            end
        end
        tick();
        if_l.shift_en = 1'b0;
        n_tests++;
        if ({if_l.busy, if_l.data_ready, if_l.bit_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL lsb_end: got {busy,rdy,bv}=%b want 010",
                     {if_l.busy, if_l.data_ready, if_l.bit_valid});
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_sout = 1'b0;
        rst = 1'b1;
        if_m.shift_en = 1'b0; if_m.data_in = '0; if_m.data_valid = 1'b0;
        if_l.shift_en = 1'b0; if_l.data_in = '0; if_l.data_valid = 1'b0;
        test_reset();
        test_msb_basic();
        test_sparse_strobe();
        test_back_to_back();
        test_reset_midframe();
        test_lsb_first();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
